// File: rtl/bypass_pkg.sv
// Shared types and constants for the CABAC bypass multi-bin decoder.
// No logic of its own; zero latency.
// No flow control; imported by the lane and the top.
package bypass_pkg;

   // Left shift that turns a 9-bit range into the 16-bit scaled range.
   localparam int SCALE_SHIFT = 7;
   localparam int RANGE_W     = 9;
   localparam int VALUE_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bypass_lane.sv
// One bypass bin step: shift the next stream bit into value, compare with the scaled range.
// Purely combinational, zero latency; chained LANES deep in the top.
// No flow control; the top decides which lane results are used.
module bypass_lane
   import bypass_pkg::*;
(
   input  logic [VALUE_W-1:0] value,
   input  logic [VALUE_W-1:0] scaled_range,
   input  logic               bit_val,
   output logic               bin,
   output logic [VALUE_W-1:0] value_next
);

   logic [VALUE_W:0] v17;
   logic [VALUE_W:0] diff;

   // 17-bit working value so the compare cannot overflow.
   assign v17        = {value, bit_val};
   assign diff       = v17 - {1'b0, scaled_range};
   assign bin        = (v17 >= {1'b0, scaled_range});
   assign value_next = bin ? diff[VALUE_W-1:0] : v17[VALUE_W-1:0];

endmodule

// File: rtl/bypass_multibin_decoder.sv
// Decodes a run of 0..MAX_BINS CABAC bypass bins, up to LANES per clock, from its own bit buffer.
// Latency: result registered ceil(N/LANES)+1 cycles after command accept (1 for N=0), plus starved cycles.
// Backpressure: one command in flight; result held until res_ready; bytes accepted while buffer has room for 8 bits.
module bypass_multibin_decoder
   import bypass_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int MAX_BINS = 32,
   parameter int BUF_BITS = 16,
   parameter int NB_W     = $clog2(MAX_BINS + 1),
   localparam int CNT_W   = $clog2(BUF_BITS + 1)
)
(
   input  logic                clk,
   input  logic                rst,

   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [NB_W-1:0]     cmd_num_bins,
   input  logic [RANGE_W-1:0]  cmd_range,
   input  logic [VALUE_W-1:0]  cmd_value,

   input  logic                bs_valid,
   output logic                bs_ready,
   input  logic [7:0]          bs_data,

   output logic                res_valid,
   input  logic                res_ready,
   output logic [MAX_BINS-1:0] res_bins,
   output logic [VALUE_W-1:0]  res_value,

   output logic [CNT_W-1:0]    buf_count
);

   localparam int K_W = $clog2(LANES + 1);

   state_t               state;
   logic [RANGE_W-1:0]   range_q;
   logic [VALUE_W-1:0]   value_q;
   logic [MAX_BINS-1:0]  acc_q;
   logic [NB_W-1:0]      remaining;

   // Oldest buffered bit sits at the MSB; valid bits are left-aligned, the rest are zero.
   logic [BUF_BITS-1:0]  bit_buf;

   logic [VALUE_W-1:0]   scaled_range;
   logic [NB_W-1:0]      clamped;
   int                   k_int;
   logic [K_W-1:0]       k;
   logic [VALUE_W-1:0]   lane_val [LANES+1];
   logic [LANES-1:0]     lane_bin;
   logic [VALUE_W-1:0]   value_next;
   logic [MAX_BINS-1:0]  acc_next;

   logic                 accept;
   logic [CNT_W-1:0]     rem_bits;
   logic [BUF_BITS-1:0]  byte_ext;
   logic [BUF_BITS-1:0]  byte_aligned;
   logic [BUF_BITS-1:0]  buf_next;
   logic [CNT_W-1:0]     count_next;

   assign scaled_range = {range_q, {SCALE_SHIFT{1'b0}}};
   assign clamped      = (cmd_num_bins > NB_W'(MAX_BINS)) ? NB_W'(MAX_BINS) : cmd_num_bins;

   // Bins this cycle: limited by lane count, bins still owed and bits on hand.
   always_comb begin
      k_int = 0;
      if (state == RUN) begin
         k_int = LANES;
         if (int'(remaining) < k_int) k_int = int'(remaining);
         if (int'(buf_count) < k_int) k_int = int'(buf_count);
      end
      k = K_W'(k_int);
   end

   // Lane chain: lane i consumes buffer bit i, oldest first.
   assign lane_val[0] = value_q;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      bypass_lane u_lane (
         .value        (lane_val[i]),
         .scaled_range (scaled_range),
         .bit_val      (bit_buf[BUF_BITS-1-i]),
         .bin          (lane_bin[i]),
         .value_next   (lane_val[i+1])
      );
   end

   // Keep only the first k lane results for value and the bin accumulator.
   always_comb begin
      value_next = lane_val[k];
      acc_next   = acc_q;
      for (int i = 0; i < LANES; i++) begin
         if (i < k_int) acc_next = (acc_next << 1) | MAX_BINS'(lane_bin[i]);
      end
   end

   // Buffer bookkeeping: consume from the pre-cycle contents, append the new byte behind what is left.
   assign bs_ready     = (buf_count <= CNT_W'(BUF_BITS - 8));
   assign accept       = bs_valid & bs_ready;
   assign rem_bits     = buf_count - CNT_W'(k);
   assign byte_ext     = BUF_BITS'(bs_data);
   assign byte_aligned = byte_ext << (CNT_W'(BUF_BITS - 8) - rem_bits);
   assign buf_next     = (bit_buf << k) | (accept ? byte_aligned : '0);
   assign count_next   = rem_bits + (accept ? CNT_W'(8) : CNT_W'(0));

   // Bit buffer register, live in every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_buf   <= '0;
         buf_count <= '0;
      end else begin
         bit_buf   <= buf_next;
         buf_count <= count_next;
      end
   end

   // Command FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         res_bins  <= '0;
         res_value <= '0;
         range_q   <= '0;
         value_q   <= '0;
         acc_q     <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  range_q   <= cmd_range;
                  value_q   <= cmd_value;
                  acc_q     <= '0;
                  remaining <= clamped;
                  cmd_ready <= 1'b0;
                  if (clamped == '0) begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_bins  <= '0;
                     res_value <= cmd_value;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               value_q   <= value_next;
               acc_q     <= acc_next;
               remaining <= remaining - NB_W'(k);
               if (remaining == NB_W'(k)) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_bins  <= acc_next;
                  res_value <= value_next;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
